rr_arb8: RTL and testbench

- Round-robin arbiter that shares the 8:1 enabled selector (8-bit data in, 3-bit select, enable, 1-bit out) among 8 requesters.
- Drives the selector's select and enable directly, plus one-hot grants back to the requesters.
- Sits between the game's per-lane/per-object request sources and the shared selector output path.
- Enforces one-cycle dead time between owners and a programmable maximum hold time.

---
 rtl/rr_arb8_pkg.sv | 16 +
 rtl/rr_arb8_pick.sv | 29 ++
 rtl/rr_arb8.sv | 119 +++++++++++
 tb/tb_rr_arb8.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin selector arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_arb8_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb8_pick.sv
// Rotating priority pick: first requester at or after ptr, wrapping modulo 8.
// Latency: purely combinational.
// Backpressure: none; any=0 means nothing to pick and idx is don't-care (ptr).
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = SEL_W'(i);
    end
    idx = ptr + off;
    any = |req;
  end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter owning the shared 8:1 enabled selector; drives sel/e and one-hot gnt.
// Latency: 1 cycle req->gnt/e from IDLE; one dead cycle (RELEASE) between owners.
// Backpressure: no preemption; owner holds until done, its req drops, or HOLD_MAX expires.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             e,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  localparam logic             HOLD_EN  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             own_req;
  logic             hold_hit;
  logic             grant_exit;
  logic             forced;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Exit conditions for the current owner; timeout only when the hold limit is the sole cause.
  always_comb begin
    own_req    = req[sel];
    hold_hit   = HOLD_EN && (cnt == HOLD_LIM);
    grant_exit = done || !own_req || hold_hit;
    forced     = !done && own_req && hold_hit;
  end

  // Arbiter FSM with registered selector controls, grants, status and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      e       <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (pick_any) begin
            state <= ST_GRANT;
            sel   <= pick_idx;
            gnt   <= N_REQ'(1) << pick_idx;
            e     <= 1'b1;
            busy  <= 1'b1;
            cnt   <= CNT_W'(1);
          end else begin
            e    <= 1'b0;
            gnt  <= '0;
            busy <= 1'b0;
          end
        end

        ST_GRANT: begin
          if (grant_exit) begin
            // ptr moves past the owner now so the RELEASE-cycle pick already sees it.
            state   <= ST_RELEASE;
            e       <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b1;
            timeout <= forced;
            ptr     <= sel + SEL_W'(1);
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          timeout <= 1'b0;
          if (pick_any) begin
            state <= ST_GRANT;
            sel   <= pick_idx;
            gnt   <= N_REQ'(1) << pick_idx;
            e     <= 1'b1;
            busy  <= 1'b1;
            cnt   <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          e       <= 1'b0;
          gnt     <= '0;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with HOLD_MAX=4 and hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: n/a.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       e;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int total;
  int bad;

  rr_arb8 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .e       (e),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'h10;
    done  = 1'b0;

    // Reset held with a pending request
    tick();
    tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_e", 32'(e), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);

    // Single requester: grant one cycle after reset release
    rst_n = 1'b1;
    tick();
    chk("single_sel", 32'(sel), 32'd4);
    chk("single_gnt", 32'(gnt), 32'h10);
    chk("single_e", 32'(e), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    chk("single_rel_e", 32'(e), 32'd0);
    chk("single_rel_gnt", 32'(gnt), 32'h00);
    chk("single_rel_sel", 32'(sel), 32'd4);
    chk("single_rel_busy", 32'(busy), 32'd1);
    done = 1'b0;
    req  = 8'h00;
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_e", 32'(e), 32'd0);

    // Async reset between edges to bring ptr back to 0
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Fairness: all request, done pulsed each grant
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("rr_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
      chk("rr_sel", 32'(sel), 32'(k % 8));
      chk("rr_e", 32'(e), 32'd1);
      done = 1'b1;
      tick();
      chk("rr_dead_e", 32'(e), 32'd0);
      chk("rr_dead_gnt", 32'(gnt), 32'h00);
      done = 1'b0;
      if (k != 8) tick();
    end

    // Pointer wrap: owner 6 releases, then req=0x05 goes to 0 then 2
    req = 8'h40;
    tick();
    chk("wrap_g6", 32'(gnt), 32'h40);
    done = 1'b1;
    tick();
    chk("wrap_rel6_e", 32'(e), 32'd0);
    done = 1'b0;
    req  = 8'h05;
    tick();
    chk("wrap_sel0", 32'(sel), 32'd0);
    chk("wrap_gnt0", 32'(gnt), 32'h01);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("wrap_sel2", 32'(sel), 32'd2);
    chk("wrap_gnt2", 32'(gnt), 32'h04);
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    tick();
    chk("wrap_idle_busy", 32'(busy), 32'd0);

    // Timeout: HOLD_MAX=4 with req held and no done
    req = 8'h08;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("to_hold_e", 32'(e), 32'd1);
      chk("to_hold_gnt", 32'(gnt), 32'h08);
      chk("to_hold_pulse", 32'(timeout), 32'd0);
      tick();
    end
    chk("to_rel_e", 32'(e), 32'd0);
    chk("to_rel_pulse", 32'(timeout), 32'd1);
    chk("to_rel_busy", 32'(busy), 32'd1);
    tick();
    chk("to_regrant_gnt", 32'(gnt), 32'h08);
    chk("to_regrant_sel", 32'(sel), 32'd3);
    chk("to_regrant_pulse", 32'(timeout), 32'd0);

    // Same setup, done on the 4th grant cycle: no timeout
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("tod_hold_e", 32'(e), 32'd1);
    end
    done = 1'b1;
    tick();
    chk("tod_rel_e", 32'(e), 32'd0);
    chk("tod_rel_pulse", 32'(timeout), 32'd0);
    done = 1'b0;
    req  = 8'h00;
    tick();
    chk("tod_idle_busy", 32'(busy), 32'd0);

    // Request drop: owner 5 drops while requester 1 waits
    req = 8'h20;
    tick();
    chk("drop_g5", 32'(gnt), 32'h20);
    req = 8'h02;
    tick();
    chk("drop_rel_e", 32'(e), 32'd0);
    chk("drop_rel_pulse", 32'(timeout), 32'd0);
    tick();
    chk("drop_gnt1", 32'(gnt), 32'h02);
    chk("drop_sel1", 32'(sel), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Async reset mid-grant
    req = 8'h20;
    tick();
    chk("ar_g5", 32'(gnt), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h00);
    chk("ar_e", 32'(e), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_sel", 32'(sel), 32'd0);
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_first_gnt", 32'(gnt), 32'h01);
    chk("ar_first_sel", 32'(sel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
